lfsr_bist_controller: RTL and testbench
=======================================

Name: lfsr_bist_controller

Overview:
Sequencer for a BIST session built around the 4-bit primitive LFSR pattern generator (x^4+x^3+1 feedback). On `start` it seeds the LFSR and drives NUM_PATTERNS patterns to the circuit-under-test (CUT). It compacts the CUT responses into a 4-bit MISR, then compares the final signature against GOLDEN and reports pass or fail. It sits between the test-mode host logic and the CUT as the single owner of pattern generation and signature analysis.

Parameters:
SEED, 4'b0001, LFSR seed loaded at session start; the value 4'b0000 is replaced by 4'b0001 to avoid lock-up.
NUM_PATTERNS, 15, number of patterns applied per session; legal range 1..15.
RESP_LATENCY, 1, cycles from `pattern` being driven to the matching `cut_resp` being valid; legal range 1..3.
GOLDEN, 4'b0000, expected final MISR signature.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous active-high reset.
start  input  1  one-cycle pulse that begins a session; honoured only in IDLE or DONE.
abort  input  1  synchronous abort request; returns the block to IDLE on the next edge.
cut_resp  input  4  CUT response, sampled RESP_LATENCY cycles after the matching pattern.
pattern  output  4  current LFSR state driven to the CUT.
pattern_valid  output  1  high while `pattern` holds a pattern to be applied.
busy  output  1  high in SEED, RUN and DRAIN.
done  output  1  high in DONE; held until the next `start`, `abort` or `rst`.
pass  output  1  valid only when `done`=1: 1 if signature==GOLDEN.
signature  output  4  MISR contents; live during a session, frozen in DONE.
pat_count  output  4  number of patterns issued in the current session.

Behaviour:
- Reset (sync, rst=1 at an edge): state=IDLE.
  - Output reset values: pattern=0000, pattern_valid=0, busy=0, done=0, pass=0, signature=0000, pat_count=0.
  - rst has priority over `abort` and `start`.
- LFSR step: next={s[0], s[3]^s[0], s[2], s[1]}.
  - Sequence from 0001 (period 15): 0001,1100,0110,0011,1101,1010,0101,1110,0111,1111,1011,1001,1000,0100,0010.
- MISR step: next={m[0], m[3]^m[0], m[2], m[1]} ^ cut_resp. The MISR seed is 0000.
- FSM states: IDLE, SEED, RUN, DRAIN, DONE.
- IDLE/DONE + start → SEED.
  - The same edge clears done, pass, signature and pat_count.
- SEED (1 cycle): loads LFSR with SEED (0000→0001). pattern_valid=0. Next state is RUN.
- RUN:
  - pattern_valid=1 and pattern=LFSR state.
  - Each cycle the LFSR steps and pat_count increments.
  - On the edge that pat_count reaches NUM_PATTERNS, the state moves to DRAIN and pattern_valid drops.
  - RUN therefore lasts exactly NUM_PATTERNS cycles.
- Response capture:
  - A RESP_LATENCY-deep valid delay line follows pattern_valid.
  - The MISR updates only on cycles where the delayed valid is 1, so exactly NUM_PATTERNS responses are compacted.
- DRAIN: waits until the delay line is empty (RESP_LATENCY cycles), then moves to DONE.
- DONE: signature is frozen, pass=(signature==GOLDEN), done=1.
- Session timing: `start` edge to `done`=1 is 1+NUM_PATTERNS+RESP_LATENCY+1 edges.
  - Default parameters: 18 cycles.
- start while busy: ignored. No restart and no state change.
- abort in any state:
  - Next state is IDLE; busy=0, done=0, pass=0, pattern_valid=0.
  - The delay line is flushed, so in-flight responses are discarded.
  - signature and pat_count hold their last values.
  - If abort and start arrive in the same cycle, abort wins.
- rst mid-session: identical to power-on reset, and takes effect at the next edge.
- pattern holds its last value when pattern_valid=0.

Test Plan:
1. Reset, then start with defaults and cut_resp=0000.
   → pattern is the 15-value sequence above, starting 0001 on the first RUN cycle.
   → done rises 18 cycles after the start edge; signature=0000, pass=1.
2. NUM_PATTERNS=15, RESP_LATENCY=1, cut_resp=pattern delayed 1 cycle, GOLDEN from the bench model.
   → signature matches the model's MISR result, pass=1.
   → Repeat with one bit of cut_resp flipped on pattern 7 → pass=0.
3. RESP_LATENCY=3, NUM_PATTERNS=4.
   → exactly 4 MISR updates occur, none before the 3rd RUN cycle.
   → done 9 cycles after start; pat_count=4.
4. start pulsed again at RUN cycle 5.
   → ignored: the sequence continues unbroken and pat_count still ends at 15.
5. abort at RUN cycle 6.
   → next cycle: IDLE, busy=0, pattern_valid=0, done=0.
   → a new start then yields the full, correct session.
6. SEED=0000.
   → first pattern=0001, not 0000.
   → rst asserted during DRAIN → all outputs return to their reset values next cycle.

Source files
------------

// File: rtl/lfsr_bist_controller.sv
// rtl/lfsr_bist_controller.sv - BIST sequencer: 4-bit LFSR pattern source, 4-bit MISR compactor, golden compare.
module lfsr_bist_controller #(
   parameter logic [3:0] SEED         = 4'b0001,
   parameter int         NUM_PATTERNS = 15,
   parameter int         RESP_LATENCY = 1,
   parameter logic [3:0] GOLDEN       = 4'b0000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       abort,
   input  logic [3:0] cut_resp,
   output logic [3:0] pattern,
   output logic       pattern_valid,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] signature,
   output logic [3:0] pat_count
);

   typedef enum logic [2:0] {S_IDLE, S_SEED, S_RUN, S_DRAIN, S_DONE} state_t;

   // An all-zero seed would lock the LFSR, so it is promoted to 0001.
   localparam logic [3:0] SEED_EFF = (SEED == 4'b0000) ? 4'b0001 : SEED;
   localparam logic [3:0] LAST_CNT = 4'(NUM_PATTERNS - 1);

   state_t                  state, state_nxt;
   logic [RESP_LATENCY-1:0] resp_dly;
   logic                    resp_valid;
   logic                    start_ok;
   logic                    last_pat;
   logic [3:0]              lfsr_next;
   logic [3:0]              misr_next;

   assign resp_valid = resp_dly[RESP_LATENCY-1];
   assign start_ok   = start && (state == S_IDLE || state == S_DONE);
   assign last_pat   = (pat_count == LAST_CNT);
   assign lfsr_next  = {pattern[0], pattern[3] ^ pattern[0], pattern[2], pattern[1]};
   assign misr_next  = {signature[0], signature[3] ^ signature[0], signature[2], signature[1]} ^ cut_resp;

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt     = state;
      pattern_valid = 1'b0;
      busy          = 1'b0;
      done          = 1'b0;
      case (state)
         S_IDLE:  if (start) state_nxt = S_SEED;
         S_SEED: begin
            busy      = 1'b1;
            state_nxt = S_RUN;
         end
         S_RUN: begin
            busy          = 1'b1;
            pattern_valid = 1'b1;
            if (last_pat) state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            busy = 1'b1;
            if (resp_dly == '0) state_nxt = S_DONE;
         end
         S_DONE: begin
            done = 1'b1;
            if (start) state_nxt = S_SEED;
         end
         default: state_nxt = S_IDLE;
      endcase
      if (abort) state_nxt = S_IDLE;
   end

   assign pass = done && (signature == GOLDEN);

   // Abort freezes pattern, count and signature; only the response pipe is flushed.
   always_ff @(posedge clk) begin
      if (rst) begin
         pattern   <= 4'b0000;
         signature <= 4'b0000;
         pat_count <= 4'b0000;
         resp_dly  <= '0;
      end else if (abort) begin
         resp_dly  <= '0;
      end else begin
         resp_dly <= RESP_LATENCY'({resp_dly, pattern_valid});
         if (start_ok) begin
            signature <= 4'b0000;
            pat_count <= 4'b0000;
         end
         if (state == S_SEED) pattern <= SEED_EFF;
         if (state == S_RUN) begin
            pat_count <= pat_count + 4'd1;
            if (!last_pat) pattern <= lfsr_next;
         end
         if (resp_valid) signature <= misr_next;
      end
   end

endmodule

// File: tb/tb_lfsr_bist_controller.sv
// tb/tb_lfsr_bist_controller.sv - self-checking bench for lfsr_bist_controller.
module tb_lfsr_bist_controller;

   localparam logic [59:0] SEQ_P = {4'h2, 4'h4, 4'h8, 4'h9, 4'hB, 4'hF, 4'h7, 4'hE,
                                    4'h5, 4'hA, 4'hD, 4'h3, 4'h6, 4'hC, 4'h1};

   function automatic logic [3:0] misr_step(input logic [3:0] m, input logic [3:0] r);
      logic [3:0] lsb;
      lsb = {3'b000, m[0]};
      return ((m >> 1) | (lsb << 3)) ^ (lsb << 2) ^ r;
   endfunction

   function automatic logic [3:0] echo_golden();
      logic [3:0] m;
      m = 4'h0;
      for (int k = 0; k < 15; k++) m = misr_step(m, SEQ_P[4*k +: 4]);
      return m;
   endfunction

   localparam logic [3:0]  GOLD1 = echo_golden();
   localparam logic [15:0] NPS   = {4'd15, 4'd4, 4'd15, 4'd15};
   localparam logic [15:0] LATS  = {4'd1, 4'd3, 4'd1, 4'd1};
   localparam logic [15:0] SEEDS = {4'h0, 4'h1, 4'h1, 4'h1};
   localparam logic [15:0] GOLDS = {4'h0, 4'h0, GOLD1, 4'h0};

   typedef struct {
      logic [3:0] resp;
      logic [3:0] pat;
      logic [3:0] cnt;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       start_v [4];
   logic       abort_v [4];
   logic [3:0] cut_v   [4];
   logic [3:0] pat_o   [4];
   logic       pv_o    [4];
   logic       busy_o  [4];
   logic       done_o  [4];
   logic       pass_o  [4];
   logic [3:0] sig_o   [4];
   logic [3:0] cnt_o   [4];

   vec_t       tbl [15];
   int         n_cmp = 0;
   int         n_bad = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      lfsr_bist_controller #(
         .SEED(SEEDS[4*g +: 4]),
         .NUM_PATTERNS(int'(NPS[4*g +: 4])),
         .RESP_LATENCY(int'(LATS[4*g +: 4])),
         .GOLDEN(GOLDS[4*g +: 4])
      ) u_dut (
         .clk(clk),
         .rst(rst),
         .start(start_v[g]),
         .abort(abort_v[g]),
         .cut_resp(cut_v[g]),
         .pattern(pat_o[g]),
         .pattern_valid(pv_o[g]),
         .busy(busy_o[g]),
         .done(done_o[g]),
         .pass(pass_o[g]),
         .signature(sig_o[g]),
         .pat_count(cnt_o[g])
      );
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input int u, input int c,
                      input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s u%0d c%0d: got %0h expected %0h", nm, u, c, act, exp);
      end
   endtask

   task automatic chk_reset(input int u, input string tag);
      chk({tag, "_pattern"}, u, -1, pat_o[u], 0);
      chk({tag, "_pv"},      u, -1, pv_o[u], 0);
      chk({tag, "_busy"},    u, -1, busy_o[u], 0);
      chk({tag, "_done"},    u, -1, done_o[u], 0);
      chk({tag, "_pass"},    u, -1, pass_o[u], 0);
      chk({tag, "_sig"},     u, -1, sig_o[u], 0);
      chk({tag, "_cnt"},     u, -1, cnt_o[u], 0);
   endtask

   // Full session with responses resp[k] driven lat cycles after pattern k; junk elsewhere.
   task automatic run_session(input int u, input logic [3:0] resp [15], input int restart_at);
      int         n, lat, idx;
      logic [3:0] m;
      n   = int'(NPS[4*u +: 4]);
      lat = int'(LATS[4*u +: 4]);
      m   = 4'h0;
      start_v[u] = 1'b1;
      cut_v[u]   = 4'($urandom);
      tick;
      start_v[u] = 1'b0;
      chk("seed_busy", u, 0, busy_o[u], 1);
      chk("seed_pv",   u, 0, pv_o[u], 0);
      chk("seed_done", u, 0, done_o[u], 0);
      chk("clr_sig",   u, 0, sig_o[u], 0);
      chk("clr_cnt",   u, 0, cnt_o[u], 0);
      for (int c = 0; c < n + lat + 2; c++) begin
         if (c >= 1 && c <= n) begin
            chk("run_pattern", u, c, pat_o[u], tbl[c-1].pat);
            chk("run_pv",      u, c, pv_o[u], 1);
            chk("run_cnt",     u, c, cnt_o[u], tbl[c-1].cnt);
         end else if (c > n) begin
            chk("drain_pv",   u, c, pv_o[u], 0);
            chk("drain_busy", u, c, busy_o[u], 1);
            chk("drain_done", u, c, done_o[u], 0);
         end
         chk("live_sig", u, c, sig_o[u], m);
         idx        = c - 1 - lat;
         cut_v[u]   = (idx >= 0 && idx < n) ? resp[idx] : 4'($urandom);
         start_v[u] = (c == restart_at);
         tick;
         if (c - lat - 1 >= 0 && c - lat - 1 < n) m = misr_step(m, resp[c-lat-1]);
      end
      start_v[u] = 1'b0;
      chk("done_done",    u, n + lat + 2, done_o[u], 1);
      chk("done_busy",    u, n + lat + 2, busy_o[u], 0);
      chk("done_pv",      u, n + lat + 2, pv_o[u], 0);
      chk("done_sig",     u, n + lat + 2, sig_o[u], m);
      chk("done_pass",    u, n + lat + 2, pass_o[u], (m == GOLDS[4*u +: 4]));
      chk("done_cnt",     u, n + lat + 2, cnt_o[u], n);
      chk("done_pattern", u, n + lat + 2, pat_o[u], tbl[n-1].pat);
      tick;
      chk("done_hold", u, n + lat + 3, done_o[u], 1);
      chk("sig_frozen", u, n + lat + 3, sig_o[u], m);
   endtask

   initial begin
      logic [3:0] zero [15];
      logic [3:0] echo [15];
      logic [3:0] rnd  [15];
      logic [3:0] m;

      for (int k = 0; k < 15; k++) begin
         tbl[k].pat  = SEQ_P[4*k +: 4];
         tbl[k].resp = SEQ_P[4*k +: 4];
         tbl[k].cnt  = 4'(k);
         zero[k]     = 4'h0;
         echo[k]     = tbl[k].resp;
      end
      for (int g = 0; g < 4; g++) begin
         start_v[g] = 1'b0;
         abort_v[g] = 1'b0;
         cut_v[g]   = 4'h0;
      end
      rst = 1'b1;
      tick;
      tick;
      rst = 1'b0;
      chk_reset(0, "por");
      chk_reset(2, "por");

      // Default parameters, all-zero responses: signature 0000 and pass.
      run_session(0, zero, -1);

      // Echoed responses against the model-derived golden, then one flipped bit.
      run_session(1, echo, -1);
      echo[7] = echo[7] ^ 4'b0100;
      run_session(1, echo, -1);
      chk("flip_pass", 1, 0, pass_o[1], 0);
      echo[7] = echo[7] ^ 4'b0100;

      // Short session with a three-cycle response latency.
      for (int k = 0; k < 15; k++) rnd[k] = 4'($urandom);
      run_session(2, rnd, -1);

      // A start pulse in the middle of RUN is ignored.
      for (int k = 0; k < 15; k++) rnd[k] = 4'($urandom);
      run_session(0, rnd, 6);

      // Abort during RUN: everything freezes, in-flight responses dropped.
      start_v[0] = 1'b1;
      tick;
      start_v[0] = 1'b0;
      m = 4'h0;
      for (int c = 0; c < 7; c++) begin
         cut_v[0]   = (c >= 2) ? echo[c-2] : 4'($urandom);
         abort_v[0] = (c == 6);
         tick;
         if (c >= 2 && c < 6) m = misr_step(m, echo[c-2]);
      end
      abort_v[0] = 1'b0;
      chk("abort_busy",    0, 7, busy_o[0], 0);
      chk("abort_pv",      0, 7, pv_o[0], 0);
      chk("abort_done",    0, 7, done_o[0], 0);
      chk("abort_pass",    0, 7, pass_o[0], 0);
      chk("abort_pattern", 0, 7, pat_o[0], tbl[5].pat);
      chk("abort_cnt",     0, 7, cnt_o[0], 5);
      chk("abort_sig",     0, 7, sig_o[0], m);
      start_v[0] = 1'b1;
      abort_v[0] = 1'b1;
      tick;
      start_v[0] = 1'b0;
      abort_v[0] = 1'b0;
      chk("abort_beats_start", 0, 8, busy_o[0], 0);
      tick;
      chk("idle_stays", 0, 9, busy_o[0], 0);
      run_session(0, echo, -1);

      // Randomised sessions, back to back from DONE.
      for (int s = 0; s < 4; s++) begin
         for (int k = 0; k < 15; k++) rnd[k] = 4'($urandom);
         run_session((s % 2 == 0) ? 0 : 2, rnd, -1);
      end

      // Zero seed is promoted, then reset lands in DRAIN.
      for (int k = 0; k < 15; k++) rnd[k] = 4'($urandom_range(15, 1));
      run_session(3, rnd, -1);
      start_v[3] = 1'b1;
      tick;
      start_v[3] = 1'b0;
      for (int c = 0; c < 16; c++) begin
         cut_v[3] = (c >= 2) ? rnd[c-2] : 4'h0;
         tick;
      end
      chk("pre_rst_drain", 3, 16, busy_o[3] & ~pv_o[3], 1);
      rst = 1'b1;
      tick;
      rst = 1'b0;
      chk_reset(3, "mid_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
